// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, two-flop sync, one-entry holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
module uart_rx #(
  parameter int unsigned CLK_PER_HALF_BIT = 5208
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       ferr,
  output logic       overrun,
  output logic       rx_busy
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [31:0] HALF = 32'(CLK_PER_HALF_BIT);
  localparam logic [31:0] FULL = 32'(2 * CLK_PER_HALF_BIT);

  state_e      state_q;
  logic [31:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  sh_q;
  logic [7:0]  rdata_q;
  logic        valid_q;
  logic        ferr_q;
  logic        ovr_q;
  logic        s1_q;
  logic        rxs_q;
  logic        smp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q  <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      s1_q  <= rxd;
      rxs_q <= s1_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Decision one cycle past mid, so the start point shifts by one.
  localparam logic [31:0] START_AT = HALF;
  logic h1_q;
  logic h2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h1_q <= 1'b1;
      h2_q <= 1'b1;
    end else begin
      h1_q <= rxs_q;
      h2_q <= h1_q;
    end
  end

  assign smp = (h2_q & h1_q) | (h2_q & rxs_q) | (h1_q & rxs_q);
`else
  localparam logic [31:0] START_AT = HALF - 32'd1;
  assign smp = rxs_q;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (rx_ack && valid_q) valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rxs_q) state_q <= START;
        end
        START: begin
          if (cnt_q == START_AT) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= smp ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        DATA: begin
          if (cnt_q == FULL - 32'd1) begin
            cnt_q <= '0;
            sh_q  <= {smp, sh_q[7:1]};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        STOP: begin
          if (cnt_q == FULL - 32'd1) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (!smp) begin
              ferr_q <= 1'b1;
            end else if (valid_q && !rx_ack) begin
              ovr_q <= 1'b1;
            end else begin
              rdata_q <= sh_q;
              valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata    = rdata_q;
  assign rx_valid = valid_q;
  assign ferr     = ferr_q;
  assign overrun  = ovr_q;
  assign rx_busy  = (state_q != IDLE);
endmodule
